// File: rtl/imem_loader_if.sv
// Byte-stream load port and CPU fetch port of the loadable instruction memory.
// master drives bytes and fetch addresses; slave returns ready and the fetched word.
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [15:0] pc;
    logic [15:0] instruction;

    modport master (
        output in_valid,
        output in_data,
        output pc,
        input  in_ready,
        input  instruction
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  pc,
        output in_ready,
        output instruction
    );
endinterface

// File: rtl/imem_loader.sv
// Double-banked instruction memory loaded from a checksummed byte frame; fetch is combinational.
// Commit/abort take effect on the last accepted byte edge; in_ready drops for one cool-down cycle after each frame.
module imem_loader #(
    parameter int WORDS   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus,
    output logic         cpu_hold,
    output logic         load_done,
    output logic         load_err,
    output logic [1:0]   err_code,
    output logic         active_bank
);
    localparam int AW = $clog2(WORDS);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_DATA_HI,
        S_DATA_LO,
        S_CHECK,
        S_COOL
    } state_t;

    state_t          state_q, state_nxt;
    logic            rdy_q;
    logic [AW:0]     active_count;
    logic [AW:0]     cnt_q;
    logic [AW:0]     idx_q;
    logic [7:0]      sum_q;
    logic [7:0]      hi_q;
    logic [TW-1:0]   timer_q;
    logic [15:0]     mem [2][WORDS];

    logic            accept;
    logic            busy;
    logic            hdr;
    logic            wr;
    logic            commit;
    logic            abort;
    logic [1:0]      err_nxt;

    assign accept       = bus.in_valid && rdy_q;
    assign busy         = (state_q == S_COUNT) || (state_q == S_DATA_HI) ||
                          (state_q == S_DATA_LO) || (state_q == S_CHECK);
    assign bus.in_ready = rdy_q;

    always_comb begin
        state_nxt = state_q;
        hdr       = 1'b0;
        wr        = 1'b0;
        commit    = 1'b0;
        abort     = 1'b0;
        err_nxt   = 2'd0;
        case (state_q)
            S_IDLE: begin
                if (accept && bus.in_data == 8'hA5) begin
                    hdr       = 1'b1;
                    state_nxt = S_COUNT;
                end
            end
            S_COUNT: begin
                if (accept) begin
                    if (bus.in_data == 8'd0 || bus.in_data > 8'(WORDS)) begin
                        abort   = 1'b1;
                        err_nxt = 2'd1;
                    end else begin
                        state_nxt = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (accept) state_nxt = S_DATA_LO;
            end
            S_DATA_LO: begin
                if (accept) begin
                    wr        = 1'b1;
                    state_nxt = (idx_q + 1'b1 == cnt_q) ? S_CHECK : S_DATA_HI;
                end
            end
            S_CHECK: begin
                if (accept) begin
                    if (8'(sum_q + bus.in_data) == 8'd0) begin
                        commit = 1'b1;
                    end else begin
                        abort   = 1'b1;
                        err_nxt = 2'd2;
                    end
                end
            end
            S_COOL: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // An idle cycle can never coincide with a byte-driven abort or commit.
        if (busy && !accept && timer_q == TW'(TIMEOUT - 1)) begin
            abort   = 1'b1;
            err_nxt = 2'd3;
        end
        if (commit || abort) state_nxt = S_COOL;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rdy_q        <= 1'b0;
            cpu_hold     <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            err_code     <= 2'd0;
            active_bank  <= 1'b0;
            active_count <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            sum_q        <= 8'd0;
            hi_q         <= 8'd0;
            timer_q      <= '0;
        end else begin
            state_q   <= state_nxt;
            rdy_q     <= (state_nxt != S_COOL);
            load_done <= commit;
            load_err  <= abort;
            if (hdr) begin
                cpu_hold <= 1'b1;
                err_code <= 2'd0;
                sum_q    <= 8'd0;
                timer_q  <= '0;
            end
            if (busy) timer_q <= accept ? '0 : timer_q + 1'b1;
            if (accept && (state_q == S_COUNT || state_q == S_DATA_HI || state_q == S_DATA_LO))
                sum_q <= sum_q + bus.in_data;
            if (accept && state_q == S_COUNT) begin
                cnt_q <= bus.in_data[AW:0];
                idx_q <= '0;
            end
            if (accept && state_q == S_DATA_HI) hi_q <= bus.in_data;
            if (wr) idx_q <= idx_q + 1'b1;
            if (commit) begin
                active_bank  <= ~active_bank;
                active_count <= cnt_q;
                cpu_hold     <= 1'b0;
            end
            if (abort) begin
                cpu_hold <= 1'b0;
                err_code <= err_nxt;
            end
        end
    end

    // Loads only ever target the bank the CPU is not fetching from.
    always_ff @(posedge clk) begin
        if (wr) mem[~active_bank][idx_q[AW-1:0]] <= {hi_q, bus.in_data};
    end

    logic [AW-1:0] fetch_idx;
    logic          unused_pc0;
    assign fetch_idx  = bus.pc[AW:1];
    assign unused_pc0 = bus.pc[0];

    always_comb begin
        bus.instruction = 16'd0;
        if (bus.pc < 16'(2 * WORDS) && {1'b0, fetch_idx} < active_count)
            bus.instruction = mem[active_bank][fetch_idx];
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad frames, timeout, garbage, reset mid-frame.
module tb_imem_loader;
    localparam int TIMEOUT = 1024;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cpu_hold, load_done, load_err, active_bank;
    logic [1:0] err_code;
    int         checks = 0;
    int         errors = 0;

    imem_loader_if bus ();

    imem_loader #(.WORDS(16), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .cpu_hold    (cpu_hold),
        .load_done   (load_done),
        .load_err    (load_err),
        .err_code    (err_code),
        .active_bank (active_bank)
    );

    always #5 clk = ~clk;

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!bus.in_ready) begin
            $display("FAIL ready_wait: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
            errors++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic send_good_frame();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h81);
        send_byte(8'h80); send_byte(8'h2C); send_byte(8'hB2); send_byte(8'h1F);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.pc       = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.in_ready, cpu_hold, load_done, load_err, err_code, active_bank} !== 7'b0) begin
            $display("FAIL reset_outputs: rdy/hold/done/err/code/bank=%b%b%b%b%b%b required all 0",
                     bus.in_ready, cpu_hold, load_done, load_err, err_code, active_bank);
            errors++;
        end
        checks++;
        if (bus.instruction !== 16'h0000) begin
            $display("FAIL reset_instr: got %h required 0000", bus.instruction);
            errors++;
        end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            $display("FAIL reset_ready_rise: got %b required 1", bus.in_ready);
            errors++;
        end
    endtask

    task automatic test_good_load();
        do_reset();
        send_byte(8'hA5);
        checks++;
        if (cpu_hold !== 1'b1) begin
            $display("FAIL good_hold_on_hdr: got %b required 1", cpu_hold);
            errors++;
        end
        send_byte(8'h02); send_byte(8'h81); send_byte(8'h80); send_byte(8'h2C); send_byte(8'hB2);
        checks++;
        if (cpu_hold !== 1'b1 || load_done !== 1'b0) begin
            $display("FAIL good_hold_mid: hold=%b done=%b required 1/0", cpu_hold, load_done);
            errors++;
        end
        send_byte(8'h1F);
        checks++;
        if (load_done !== 1'b1 || cpu_hold !== 1'b0 || active_bank !== 1'b1 || err_code !== 2'd0) begin
            $display("FAIL good_commit: done=%b hold=%b bank=%b code=%0d required 1/0/1/0",
                     load_done, cpu_hold, active_bank, err_code);
            errors++;
        end
        bus.pc = 16'd0; #1;
        checks++;
        if (bus.instruction !== 16'h8180) begin
            $display("FAIL good_pc0: got %h required 8180", bus.instruction);
            errors++;
        end
        bus.pc = 16'd2; #1;
        checks++;
        if (bus.instruction !== 16'h2CB2) begin
            $display("FAIL good_pc2: got %h required 2cb2", bus.instruction);
            errors++;
        end
        bus.pc = 16'd4; #1;
        checks++;
        if (bus.instruction !== 16'h0000) begin
            $display("FAIL good_pc4: got %h required 0000", bus.instruction);
            errors++;
        end
        bus.pc = 16'd40; #1;
        checks++;
        if (bus.instruction !== 16'h0000) begin
            $display("FAIL good_pc40: got %h required 0000", bus.instruction);
            errors++;
        end
        bus.pc = 16'd0;
        @(posedge clk); #1;
        checks++;
        if (load_done !== 1'b0) begin
            $display("FAIL good_done_pulse: got %b required 0", load_done);
            errors++;
        end
    endtask

    task automatic test_checksum_fail();
        do_reset();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h81);
        send_byte(8'h80); send_byte(8'h2C); send_byte(8'hB2); send_byte(8'h20);
        checks++;
        if (load_err !== 1'b1 || err_code !== 2'd2 || active_bank !== 1'b0 || cpu_hold !== 1'b0) begin
            $display("FAIL csum_abort: err=%b code=%0d bank=%b hold=%b required 1/2/0/0",
                     load_err, err_code, active_bank, cpu_hold);
            errors++;
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            $display("FAIL csum_cool: in_ready=%b required 0", bus.in_ready);
            errors++;
        end
        bus.pc = 16'd0; #1;
        checks++;
        if (bus.instruction !== 16'h0000) begin
            $display("FAIL csum_pc0: got %h required 0000", bus.instruction);
            errors++;
        end
        bus.pc = 16'd2; #1;
        checks++;
        if (bus.instruction !== 16'h0000) begin
            $display("FAIL csum_pc2: got %h required 0000", bus.instruction);
            errors++;
        end
        bus.pc = 16'd0;
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b1 || load_err !== 1'b0 || err_code !== 2'd2) begin
            $display("FAIL csum_after: rdy=%b err=%b code=%0d required 1/0/2",
                     bus.in_ready, load_err, err_code);
            errors++;
        end
    endtask

    task automatic test_bad_count();
        do_reset();
        send_byte(8'hA5); send_byte(8'h11);
        checks++;
        if (load_err !== 1'b1 || err_code !== 2'd1 || active_bank !== 1'b0) begin
            $display("FAIL count17: err=%b code=%0d bank=%b required 1/1/0", load_err, err_code, active_bank);
            errors++;
        end
        send_byte(8'hA5);
        checks++;
        if (err_code !== 2'd0 || cpu_hold !== 1'b1) begin
            $display("FAIL count_hdr_clear: code=%0d hold=%b required 0/1", err_code, cpu_hold);
            errors++;
        end
        send_byte(8'h00);
        checks++;
        if (load_err !== 1'b1 || err_code !== 2'd1 || cpu_hold !== 1'b0) begin
            $display("FAIL count0: err=%b code=%0d hold=%b required 1/1/0", load_err, err_code, cpu_hold);
            errors++;
        end
        bus.pc = 16'd0; #1;
        checks++;
        if (bus.instruction !== 16'h0000) begin
            $display("FAIL count_pc0: got %h required 0000", bus.instruction);
            errors++;
        end
    endtask

    task automatic test_timeout();
        do_reset();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h81);
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        checks++;
        if (load_err !== 1'b0 || cpu_hold !== 1'b1) begin
            $display("FAIL timeout_early: err=%b hold=%b required 0/1", load_err, cpu_hold);
            errors++;
        end
        @(posedge clk); #1;
        checks++;
        if (load_err !== 1'b1 || err_code !== 2'd3 || cpu_hold !== 1'b0) begin
            $display("FAIL timeout_abort: err=%b code=%0d hold=%b required 1/3/0", load_err, err_code, cpu_hold);
            errors++;
        end
    endtask

    task automatic test_garbage_resync();
        logic seen_err = 1'b0;
        do_reset();
        send_byte(8'h00); seen_err |= load_err | cpu_hold;
        send_byte(8'hFF); seen_err |= load_err | cpu_hold;
        send_byte(8'h5A); seen_err |= load_err | cpu_hold;
        checks++;
        if (seen_err !== 1'b0) begin
            $display("FAIL garbage_dropped: err/hold seen=%b required 0", seen_err);
            errors++;
        end
        send_good_frame();
        checks++;
        if (load_done !== 1'b1 || active_bank !== 1'b1) begin
            $display("FAIL garbage_commit: done=%b bank=%b required 1/1", load_done, active_bank);
            errors++;
        end
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'hE0);
        bus.pc = 16'd0; #1;
        checks++;
        if (bus.instruction !== 16'h8180) begin
            $display("FAIL fetch_during_load: got %h required 8180", bus.instruction);
            errors++;
        end
        send_byte(8'h01); send_byte(8'h1E);
        checks++;
        if (load_done !== 1'b1 || active_bank !== 1'b0) begin
            $display("FAIL swap_back: done=%b bank=%b required 1/0", load_done, active_bank);
            errors++;
        end
        bus.pc = 16'd0; #1;
        checks++;
        if (bus.instruction !== 16'hE001) begin
            $display("FAIL swap_pc0: got %h required e001", bus.instruction);
            errors++;
        end
        bus.pc = 16'd2; #1;
        checks++;
        if (bus.instruction !== 16'h0000) begin
            $display("FAIL swap_pc2: got %h required 0000", bus.instruction);
            errors++;
        end
        bus.pc = 16'd0;
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        send_good_frame();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h81); send_byte(8'h80); send_byte(8'h2C);
        reset = 1'b1;
        @(posedge clk); #1;
        bus.pc = 16'd0; #1;
        checks++;
        if ({bus.in_ready, cpu_hold, load_done, load_err, err_code, active_bank} !== 7'b0 ||
            bus.instruction !== 16'h0000) begin
            $display("FAIL midreset_outputs: rdy/hold/done/err/code/bank=%b%b%b%b%b%b instr=%h required 0",
                     bus.in_ready, cpu_hold, load_done, load_err, err_code, active_bank, bus.instruction);
            errors++;
        end
        @(posedge clk); #1;
        reset = 1'b0;
        send_good_frame();
        checks++;
        if (load_done !== 1'b1 || active_bank !== 1'b1 || err_code !== 2'd0) begin
            $display("FAIL midreset_commit: done=%b bank=%b code=%0d required 1/1/0",
                     load_done, active_bank, err_code);
            errors++;
        end
        bus.pc = 16'd2; #1;
        checks++;
        if (bus.instruction !== 16'h2CB2) begin
            $display("FAIL midreset_pc2: got %h required 2cb2", bus.instruction);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_checksum_fail();
        test_bad_count();
        test_timeout();
        test_garbage_resync();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
